scan_led_mux: RTL



---
 rtl/scan_led_mux_pkg.sv | 39 +++
 rtl/scan_led_mux_if.sv | 24 ++
 rtl/scan_led_mux_seg7_decode.sv | 9 +
 rtl/scan_led_mux.sv | 113 +++++++++++
 4 files changed

// File: rtl/scan_led_mux_pkg.sv
// Shared constants and the hex-to-seven-segment table for the multiplexed display scanner.
package scan_led_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [3:0] BRIGHT_FULL = 4'd15;

  // Active-high segments {g,f,e,d,c,b,a}; lower-case b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/scan_led_mux_if.sv
// Bundle between the readout logic (master) and the display scanner (slave).
interface scan_led_mux_if #(
  parameter int N_DIGITS = 8
);
  logic                  en;
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   dp;
  logic                  lz_en;
  logic [3:0]            bright;
  logic [N_DIGITS-1:0]   scan;
  logic [3:0]            seg;
  logic [7:0]            seg7;
  logic                  frame_tick;

  modport master (
    output en, digits, dp, lz_en, bright,
    input  scan, seg, seg7, frame_tick
  );

  modport slave (
    input  en, digits, dp, lz_en, bright,
    output scan, seg, seg7, frame_tick
  );
endinterface

// File: rtl/scan_led_mux_seg7_decode.sv
// Combinational hex digit to seven-segment pattern decoder.
module seg7_decode
  import scan_led_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segs
);
  always_comb segs = hex7(hex);
endmodule

// File: rtl/scan_led_mux.sv
// Time-multiplexed hex display scanner: per-frame input snapshot, blanking, PWM dimming,
// leading-zero suppression and registered digit/segment outputs.
module scan_led_mux
  import scan_led_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DIV      = 1000,
  parameter int BLANK    = 4
) (
  input logic           clk,
  input logic           rst,
  scan_led_mux_if.slave bus
);
  localparam int SW = $clog2(DIV);
  localparam int IW = ($clog2(N_DIGITS) < 1) ? 1 : $clog2(N_DIGITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIV - 1);
  localparam logic [SW-1:0] SLOT_ON   = SW'(BLANK);
  localparam logic [SW-1:0] SLOT_PRE  = SW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [3:0]    PWM_LAST  = 4'd14;
  localparam logic [N_DIGITS-1:0] LEFT_ONLY = {1'b1, {(N_DIGITS-1){1'b0}}};

  logic [SW-1:0]         slot_cnt;
  logic [IW-1:0]         idx;
  logic [3:0]            pwm_cnt;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dp;
  logic                  snap_lz;
  logic [3:0]            snap_bright;

  logic [N_DIGITS-1:0] zero_prefix;
  logic [3:0]          cur_digit;
  logic [6:0]          cur_segs;
  logic                suppress;
  logic                lit;
  logic                slot_end;
  logic                frame_start;

  // zero_prefix[i] is set when digits 0..i are all zero; the last digit never qualifies.
  always_comb begin
    logic all_zero;
    all_zero    = 1'b1;
    zero_prefix = '0;
    for (int i = 0; i < N_DIGITS - 1; i++) begin
      all_zero       = all_zero && (snap_digits[4*i +: 4] == 4'd0);
      zero_prefix[i] = all_zero;
    end
  end

  assign cur_digit   = snap_digits[4*int'(idx) +: 4];
  assign suppress    = snap_lz && zero_prefix[idx];
  assign lit         = (snap_bright == BRIGHT_FULL) || (pwm_cnt < snap_bright);
  assign slot_end    = (slot_cnt == SLOT_LAST);
  assign frame_start = bus.en && (idx == '0) && (slot_cnt == '0);

  seg7_decode u_decode (
    .hex  (cur_digit),
    .segs (cur_segs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
      pwm_cnt  <= '0;
    end else if (!bus.en) begin
      slot_cnt <= '0;
      idx      <= '0;
      pwm_cnt  <= '0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      // Restarting just before the ON phase makes every slot's PWM pattern identical.
      if (slot_cnt == SLOT_PRE) pwm_cnt <= '0;
      else                      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
      snap_bright <= '0;
    end else if (frame_start) begin
      snap_digits <= bus.digits;
      snap_dp     <= bus.dp;
      snap_lz     <= bus.lz_en;
      snap_bright <= bus.bright;
    end
  end

  // While disabled the segment bus keeps its last pattern; only the digit enables go dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.scan       <= '0;
      bus.seg        <= '0;
      bus.seg7       <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.frame_tick <= bus.en && slot_end && (idx == IDX_LAST);
      if (!bus.en) begin
        bus.scan <= '0;
      end else begin
        bus.scan               <= ((slot_cnt >= SLOT_ON) && lit) ? (LEFT_ONLY >> idx) : '0;
        bus.seg                <= suppress ? 4'd0 : cur_digit;
        bus.seg7[SEG_DP]       <= snap_dp[idx];
        bus.seg7[SEG_G:SEG_A]  <= suppress ? 7'd0 : cur_segs;
      end
    end
  end

endmodule
